decode: RTL

//  Instruction decode stage. Consumes IF_ID latch from fetch ({pc[31:0], instr[31:0]}), reads 32x32 register file,

---
 rtl/decode.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/decode.sv
// ----------------------------------------------------------------------------
// decode : instruction decode stage
//
// Takes the fetch latch (pc + instruction), reads the 32x32 register file,
// sign-extends the immediate, builds execute controls, resolves BEQ/J and
// detects load-use hazards. The result is registered into ID_EX, one cycle
// after IF_ID. The register file write port belongs here, driven by writeback.
//
// Ports
//   clock          in   1    all state updates on posedge
//   reset          in   1    asynchronous, active low
//   IF_ID          in   64   [63:32] pc (word address), [31:0] instruction
//   if_valid       in   1    IF_ID holds a real instruction
//   wb_we          in   1    writeback write enable
//   wb_addr        in   5    writeback destination register
//   wb_data        in   32   writeback data
//   ID_EX          out  160  registered decode result
//   stall          out  1    combinational; fetch holds pc and IF_ID
//   branchFlag     out  1    registered; fetch loads branch_target next edge
//   branch_target  out  32   registered branch/jump target (word address)
// ----------------------------------------------------------------------------
module decode #(
    parameter int         NREG     = 32,
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_ADDI  = 6'h08,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [63:0]  IF_ID,
    input  logic         if_valid,
    input  logic         wb_we,
    input  logic [4:0]   wb_addr,
    input  logic [31:0]  wb_data,
    output logic [159:0] ID_EX,
    output logic         stall,
    output logic         branchFlag,
    output logic [31:0]  branch_target
);

    // ID_EX layout, msb first
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] sext;
        logic [4:0]  dest;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        alu_imm;
        logic        valid;
        logic [9:0]  pad;
    } idex_t;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] sext;

    assign pc    = IF_ID[63:32];
    assign instr = IF_ID[31:0];
    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign sext  = {{16{instr[15]}}, instr[15:0]};

    // ------------------------------------------------------------------
    // Register file: combinational read, posedge write, r0 stays zero
    // ------------------------------------------------------------------
    logic [31:0] rf [NREG];
    logic        wb_en;

    assign wb_en = wb_we && (wb_addr != 5'd0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (wb_en) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // Writeback in the same cycle wins over the stored value so the
    // instruction in decode never sees stale data.
    logic [31:0] rs_val;
    logic [31:0] rt_val;

    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (wb_en && wb_addr == rs) rs_val = wb_data;
        else if (rs != 5'd0)        rs_val = rf[rs];
        if (wb_en && wb_addr == rt) rt_val = wb_data;
        else if (rt != 5'd0)        rt_val = rf[rt];
    end

    // ------------------------------------------------------------------
    // Control generation
    // ------------------------------------------------------------------
    logic [4:0] dest;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_imm;
    logic       reads_rt;   // rt is a source operand (not a destination)

    always_comb begin
        dest      = 5'd0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alu_imm   = 1'b0;
        reads_rt  = 1'b0;
        case (op)
            OP_RTYPE: begin
                dest      = rd;
                reg_write = 1'b1;
                reads_rt  = 1'b1;
            end
            OP_ADDI: begin
                dest      = rt;
                reg_write = 1'b1;
                alu_imm   = 1'b1;
            end
            OP_LW: begin
                dest      = rt;
                reg_write = 1'b1;
                mem_read  = 1'b1;
                alu_imm   = 1'b1;
            end
            OP_SW: begin
                mem_write = 1'b1;
                alu_imm   = 1'b1;
                reads_rt  = 1'b1;
            end
            OP_BEQ: begin
                reads_rt  = 1'b1;
            end
            default: ;  // J and unknown opcodes carry no execute controls
        endcase
        // Writing r0 is meaningless; drop it so forwarding never matches r0.
        if (dest == 5'd0) reg_write = 1'b0;
    end

    // ------------------------------------------------------------------
    // Load-use hazard against the load sitting in ID_EX
    // ------------------------------------------------------------------
    idex_t idex_q;
    idex_t idex_d;
    logic  hazard;

    assign hazard = idex_q.valid && idex_q.mem_read && (idex_q.dest != 5'd0) &&
                    ((idex_q.dest == rs) || (reads_rt && idex_q.dest == rt));

    // While a taken branch is in flight the IF_ID word is wrong-path, so a
    // hazard on it is irrelevant. Reset forces the output low explicitly.
    assign stall = reset && !branchFlag && if_valid && hazard;

    // ------------------------------------------------------------------
    // Next-state: issue, bubble, branch resolution
    // ------------------------------------------------------------------
    logic        issue;
    logic        bf_d;
    logic [31:0] bt_d;

    assign issue = !branchFlag && if_valid && !stall;

    always_comb begin
        idex_d = '0;
        bf_d   = 1'b0;
        bt_d   = branch_target;
        if (issue) begin
            idex_d.pc        = pc;
            idex_d.rs_val    = rs_val;
            idex_d.rt_val    = rt_val;
            idex_d.sext      = sext;
            idex_d.dest      = dest;
            idex_d.op        = op;
            idex_d.funct     = instr[5:0];
            idex_d.reg_write = reg_write;
            idex_d.mem_read  = mem_read;
            idex_d.mem_write = mem_write;
            idex_d.alu_imm   = alu_imm;
            idex_d.valid     = 1'b1;
            if (op == OP_BEQ && rs_val == rt_val) begin
                bf_d = 1'b1;
                bt_d = pc + 32'd1 + sext;
            end else if (op == OP_J) begin
                bf_d = 1'b1;
                bt_d = {pc[31:26], instr[25:0]};
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idex_q        <= '0;
            branchFlag    <= 1'b0;
            branch_target <= '0;
        end else begin
            idex_q        <= idex_d;
            branchFlag    <= bf_d;
            branch_target <= bt_d;
        end
    end

    assign ID_EX = idex_q;

endmodule
